fetch_controller: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It sits between the core's control unit and instruction memory. It issues word-addressed fetches (PC advances by 1 per instruction), applies branch/jump redirects, honours stall and halt, and presents each fetched instruction with its address as a one-cycle valid pulse.

---
 rtl/fetch_controller_if.sv | 12 +
 rtl/fetch_controller.sv | 78 +++++++
 tb/tb_fetch_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory request/acknowledge bus
interface fetch_controller_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: PC owner and instruction-fetch sequencer with redirect, stall and halt
module fetch_controller #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_addr,
    fetch_controller_if.master   imem,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic                 halted
);
    typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_addr;
    logic              squash;
    logic              halt_pend;

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;
    assign halted         = (state == HALTED);

    // Sequencer: a redirect seen while a fetch is in flight squashes that fetch's data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pend_addr   <= '0;
            squash      <= 1'b0;
            halt_pend   <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt)
                        state <= HALTED;
                    else if (redirect_valid)
                        pc <= redirect_addr;
                    else if (run && !stall)
                        state <= REQ;
                end
                REQ: begin
                    if (!imem.imem_ack) begin
                        if (halt)
                            halt_pend <= 1'b1;
                        if (redirect_valid) begin
                            squash    <= 1'b1;
                            pend_addr <= redirect_addr;
                        end
                    end else begin
                        if (squash || redirect_valid) begin
                            pc     <= redirect_valid ? redirect_addr : pend_addr;
                            squash <= 1'b0;
                        end else begin
                            instr       <= imem.imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + ADDR_W'(1);
                        end
                        state <= (halt || halt_pend) ? HALTED : (run && !stall) ? REQ : IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized and directed checks against a transaction-level fetch model
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        run, stall, halt, redirect_valid;
    logic [31:0] redirect_addr;
    logic        instr_valid, halted, instr_valid2, halted2;
    logic [31:0] instr, instr_pc, instr2, instr_pc2;
    logic [1:0]  wait_n;
    logic        stray;
    int          wcnt;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        s_run, s_stall, s_halt, s_rv, s_ack, s_rst;
    logic [31:0] s_ra;

    logic [31:0] m_pc, m_target, m_instr, m_ipc;
    bit          m_busy, m_dead, m_drop, m_halt_later, m_valid;

    fetch_controller_if bus ();
    fetch_controller_if bus2 ();

    always #5 clk = ~clk;

    assign bus.imem_ack    = bus.imem_req ? (wcnt >= int'(wait_n)) : stray;
    assign bus.imem_rdata  = bus.imem_addr + 32'h100;
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = bus2.imem_addr + 32'h100;

    always @(posedge clk or negedge reset)
        if (!reset) wcnt <= 0;
        else if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;

    fetch_controller dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .imem(bus),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .halted(halted)
    );

    fetch_controller #(.RESET_VECTOR(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .imem(bus2),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .halted(halted2)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(logic [31:0] vec);
        m_pc = vec; m_target = '0; m_instr = '0; m_ipc = '0;
        m_busy = 0; m_dead = 0; m_drop = 0; m_halt_later = 0; m_valid = 0;
    endtask

    // One clock of the fetch contract: idle / waiting on memory / fetch completes
    task automatic model_step();
        m_valid = 0;
        if (m_dead) return;
        if (!m_busy) begin
            if (s_halt) m_dead = 1;
            else if (s_rv) m_pc = s_ra;
            else m_busy = s_run && !s_stall;
        end else if (!s_ack) begin
            if (s_halt) m_halt_later = 1;
            if (s_rv) begin m_drop = 1; m_target = s_ra; end
        end else begin
            if (m_drop || s_rv) begin
                m_pc = s_rv ? s_ra : m_target;
                m_drop = 0;
            end else begin
                m_valid = 1; m_ipc = m_pc; m_instr = m_pc + 32'h100; m_pc = m_pc + 1;
            end
            if (s_halt || m_halt_later) m_dead = 1;
            else m_busy = s_run && !s_stall;
        end
    endtask

    task automatic compare_all();
        check("imem_req", bus.imem_req, m_busy && !m_dead);
        check("imem_addr", bus.imem_addr, m_pc);
        check("instr_valid", instr_valid, m_valid);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("halted", halted, m_dead);
    endtask

    task automatic cycle();
        #1;
        s_run = run; s_stall = stall; s_halt = halt; s_rv = redirect_valid;
        s_ra = redirect_addr; s_ack = bus.imem_ack; s_rst = reset;
        @(posedge clk);
        if (s_rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(bit r, bit s, bit h, bit v, logic [31:0] a, logic [1:0] w);
        run = r; stall = s; halt = h; redirect_valid = v; redirect_addr = a; wait_n = w;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("arst_req", bus.imem_req, 0);
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instr, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_addr", bus.imem_addr, 0);
        check("arst_halted", halted, 0);
        check("arst_addr2", bus2.imem_addr, 32'hFFFF_FFFF);
        model_reset(32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        stray = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset(32'h0);
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_addr2", bus2.imem_addr, 32'hFFFF_FFFF);
        check("rst_req2", bus2.imem_req, 0);
        reset = 1'b1;
        stray = 1'b1;

        drive(1, 0, 0, 0, 0, 0);
        cycle();
        check("rv_first_addr", bus2.imem_addr, 32'hFFFF_FFFF);
        check("rv_first_req", bus2.imem_req, 1);
        cycle();
        check("rv_first_pc", instr_pc2, 32'hFFFF_FFFF);
        check("rv_first_valid", instr_valid2, 1);
        check("rv_wrap_addr", bus2.imem_addr, 0);
        cycle();
        check("rv_wrap_pc", instr_pc2, 0);
        for (int k = 4; k <= 6; k++) begin
            cycle();
            check("zw_pc", instr_pc, k - 2);
            check("zw_valid", instr_valid, 1);
        end

        drive(1, 0, 0, 0, 0, 2);
        repeat (2) begin
            cycle();
            check("wait_hold", bus.imem_addr, 5);
            check("wait_novalid", instr_valid, 0);
        end
        cycle();
        check("wait_pc", instr_pc, 5);
        check("wait_next", bus.imem_addr, 6);

        repeat (3) cycle();
        check("redir_start", bus.imem_addr, 7);
        cycle();
        drive(1, 0, 0, 1, 32'h40, 2);
        cycle();
        drive(1, 0, 0, 0, 0, 2);
        cycle();
        check("redir_addr", bus.imem_addr, 32'h40);
        check("redir_drop", instr_valid, 0);
        repeat (3) cycle();
        check("redir_pc", instr_pc, 32'h40);

        repeat (2) cycle();
        drive(1, 0, 0, 1, 32'h80, 2);
        cycle();
        check("coinc_addr", bus.imem_addr, 32'h80);
        check("coinc_drop", instr_valid, 0);
        drive(1, 0, 0, 1, 32'h10, 2);
        cycle();
        drive(1, 0, 0, 1, 32'h20, 2);
        cycle();
        drive(1, 0, 0, 0, 0, 2);
        cycle();
        check("two_redir_addr", bus.imem_addr, 32'h20);
        repeat (3) cycle();
        check("two_redir_pc", instr_pc, 32'h20);

        drive(1, 1, 0, 0, 0, 0);
        repeat (3) begin
            cycle();
            check("stall_req", bus.imem_req, 0);
            check("stall_pc", bus.imem_addr, 32'h22);
        end
        drive(1, 0, 0, 0, 0, 2);
        cycle();
        check("stall_resume", bus.imem_req, 1);
        drive(1, 0, 1, 0, 0, 2);
        cycle();
        drive(1, 0, 0, 0, 0, 2);
        repeat (2) cycle();
        check("halt_last_pc", instr_pc, 32'h22);
        check("halt_flag", halted, 1);
        repeat (5) begin
            drive(1, 0, 0, 1, $urandom, 0);
            cycle();
            check("halt_noreq", bus.imem_req, 0);
        end

        drive(1, 0, 0, 0, 0, 3);
        async_reset();
        repeat (2) cycle();
        async_reset();
        cycle();
        check("restart_addr", bus.imem_addr, 0);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 119) == 0, $urandom_range(0, 6) == 0,
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom),
                  2'($urandom_range(0, 2)));
            stray = 1'($urandom_range(0, 1));
            cycle();
            if ((halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
                async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
